// File: rtl/tri_raster_scanner.sv
// Bounding-box triangle rasteriser: one candidate pixel per cycle, valid/ready pixel stream.
// Define TRI_RASTER_BACKFACE_EN to also rasterise clockwise (area<0) triangles.
module tri_raster_scanner #(
    parameter int COORD_W  = 12,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tri_valid,
    output logic                        tri_ready,
    input  logic signed [COORD_W-1:0]   tri_ax,
    input  logic signed [COORD_W-1:0]   tri_ay,
    input  logic signed [COORD_W-1:0]   tri_bx,
    input  logic signed [COORD_W-1:0]   tri_by,
    input  logic signed [COORD_W-1:0]   tri_cx,
    input  logic signed [COORD_W-1:0]   tri_cy,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic [$clog2(SCREEN_W)-1:0] pix_x,
    output logic [$clog2(SCREEN_H)-1:0] pix_y,
    output logic                        tri_done
);

    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int EW = 2 * COORD_W + 3;

    typedef logic signed [EW-1:0] edge_t;
    typedef logic signed [COORD_W-1:0] crd_t;
    typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;

    localparam edge_t XLIM = edge_t'(SCREEN_W - 1);
    localparam edge_t YLIM = edge_t'(SCREEN_H - 1);

    function automatic edge_t sext(input crd_t v);
        return {{(EW - COORD_W){v[COORD_W-1]}}, v};
    endfunction

    function automatic edge_t efn(input edge_t ax, input edge_t ay,
                                  input edge_t bx, input edge_t by,
                                  input edge_t px, input edge_t py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    function automatic edge_t min3(input edge_t a, input edge_t b, input edge_t c);
        edge_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic edge_t max3(input edge_t a, input edge_t b, input edge_t c);
        edge_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    state_t          state_q, state_d;
    crd_t            vx_q [3];
    crd_t            vy_q [3];
    crd_t            vx_d [3];
    crd_t            vy_d [3];
    edge_t           e_q  [3];
    edge_t           e_d  [3];
    edge_t           r_q  [3];
    edge_t           r_d  [3];
    edge_t           sx_q [3];
    edge_t           sx_d [3];
    edge_t           sy_q [3];
    edge_t           sy_d [3];
    logic            neg_q, neg_d;
    logic [XW-1:0]   x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0]   y_q, y_d, ymax_q, ymax_d;
    logic            last_q, last_d;
    logic            pv_q, pv_d;
    logic [XW-1:0]   px_q, px_d;
    logic [YW-1:0]   py_q, py_d;
    logic            done_q, done_d;

    edge_t ex [3];
    edge_t ey [3];
    edge_t xlo, xhi, ylo, yhi, lox, hix, loy, hiy;
    edge_t area;
    edge_t e0 [3];
    logic  empty, accept, neg_area, adv, cov;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ex[i] = sext(vx_q[i]);
            ey[i] = sext(vy_q[i]);
        end
        lox   = min3(ex[0], ex[1], ex[2]);
        hix   = max3(ex[0], ex[1], ex[2]);
        loy   = min3(ey[0], ey[1], ey[2]);
        hiy   = max3(ey[0], ey[1], ey[2]);
        xlo   = (lox < 0) ? '0 : lox;
        xhi   = (hix > XLIM) ? XLIM : hix;
        ylo   = (loy < 0) ? '0 : loy;
        yhi   = (hiy > YLIM) ? YLIM : hiy;
        empty = (xhi < xlo) || (yhi < ylo);
        area  = efn(ex[0], ey[0], ex[1], ey[1], ex[2], ey[2]);
        e0[0] = efn(ex[0], ey[0], ex[1], ey[1], xlo, ylo);
        e0[1] = efn(ex[1], ey[1], ex[2], ey[2], xlo, ylo);
        e0[2] = efn(ex[2], ey[2], ex[0], ey[0], xlo, ylo);
`ifdef TRI_RASTER_BACKFACE_EN
        accept   = (area != 0);
        neg_area = (area < 0);
`else
        accept   = (area > 0);
        neg_area = 1'b0;
`endif
    end

    // Clockwise triangles cover where all edges are non-positive
    assign cov = neg_q ? ((e_q[0] <= 0) && (e_q[1] <= 0) && (e_q[2] <= 0))
                       : ((e_q[0] >= 0) && (e_q[1] >= 0) && (e_q[2] >= 0));
    assign adv = !pv_q || pix_ready;

    always_comb begin
        state_d = state_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        e_d     = e_q;
        r_d     = r_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        neg_d   = neg_q;
        x_d     = x_q;
        y_d     = y_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        last_d  = last_q;
        pv_d    = pv_q;
        px_d    = px_q;
        py_d    = py_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tri_valid) begin
                    vx_d    = '{tri_ax, tri_bx, tri_cx};
                    vy_d    = '{tri_ay, tri_by, tri_cy};
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!accept || empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    e_d     = e0;
                    r_d     = e0;
                    sx_d    = '{ey[0] - ey[1], ey[1] - ey[2], ey[2] - ey[0]};
                    sy_d    = '{ex[1] - ex[0], ex[2] - ex[1], ex[0] - ex[2]};
                    neg_d   = neg_area;
                    x_d     = xlo[XW-1:0];
                    y_d     = ylo[YW-1:0];
                    xmin_d  = xlo[XW-1:0];
                    xmax_d  = xhi[XW-1:0];
                    ymax_d  = yhi[YW-1:0];
                    last_d  = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (adv) begin
                    if (last_q) begin
                        pv_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        pv_d = cov;
                        if (cov) begin
                            px_d = x_q;
                            py_d = y_q;
                        end
                        if (x_q != xmax_q) begin
                            x_d = x_q + 1'b1;
                            for (int i = 0; i < 3; i++) e_d[i] = e_q[i] + sx_q[i];
                        end else if (y_q != ymax_q) begin
                            x_d = xmin_q;
                            y_d = y_q + 1'b1;
                            for (int i = 0; i < 3; i++) begin
                                r_d[i] = r_q[i] + sy_q[i];
                                e_d[i] = r_q[i] + sy_q[i];
                            end
                        end else begin
                            last_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < 3; i++) begin
                vx_q[i] <= '0;
                vy_q[i] <= '0;
                e_q[i]  <= '0;
                r_q[i]  <= '0;
                sx_q[i] <= '0;
                sy_q[i] <= '0;
            end
            neg_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
            last_q <= 1'b0;
            pv_q   <= 1'b0;
            px_q   <= '0;
            py_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            e_q     <= e_d;
            r_q     <= r_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            neg_q   <= neg_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymax_q  <= ymax_d;
            last_q  <= last_d;
            pv_q    <= pv_d;
            px_q    <= px_d;
            py_q    <= py_d;
            done_q  <= done_d;
        end
    end

    assign tri_ready = (state_q == IDLE);
    assign pix_valid = pv_q;
    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign tri_done  = done_q;

endmodule

// File: tb/tb_tri_raster_scanner.sv
// Directed bench for tri_raster_scanner on a 16x16 screen.
// Expected pixel lists are written out by hand or as plain raster order.
module tb_tri_raster_scanner;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tri_valid;
    logic              tri_ready;
    logic signed [11:0] tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy;
    logic              pix_valid;
    logic              pix_ready;
    logic [3:0]        pix_x;
    logic [3:0]        pix_y;
    logic              tri_done;

    int checks = 0;
    int errors = 0;
    int ex_q[$];
    int ey_q[$];
    int nacc, ndone, done_cyc, first_v;

    tri_raster_scanner #(
        .COORD_W (12),
        .SCREEN_W(16),
        .SCREEN_H(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tri_valid(tri_valid),
        .tri_ready(tri_ready),
        .tri_ax   (tri_ax),
        .tri_ay   (tri_ay),
        .tri_bx   (tri_bx),
        .tri_by   (tri_by),
        .tri_cx   (tri_cx),
        .tri_cy   (tri_cy),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .tri_done (tri_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_t2();
        int xs[10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
        int ys[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
        ex_q.delete();
        ey_q.delete();
        for (int i = 0; i < 10; i++) begin
            ex_q.push_back(xs[i]);
            ey_q.push_back(ys[i]);
        end
    endtask

    task automatic fill_full();
        ex_q.delete();
        ey_q.delete();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                ex_q.push_back(x);
                ey_q.push_back(y);
            end
    endtask

    task automatic start_tri(input int ax, input int ay, input int bx,
                             input int by, input int cx, input int cy);
        int w = 0;
        @(negedge clk);
        while (!tri_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", int'(tri_ready), 1);
        tri_ax    = 12'(ax);
        tri_ay    = 12'(ay);
        tri_bx    = 12'(bx);
        tri_by    = 12'(by);
        tri_cx    = 12'(cx);
        tri_cy    = 12'(cy);
        tri_valid = 1'b1;
        @(posedge clk);
        #1 tri_valid = 1'b0;
    endtask

    task automatic run_tri(input int ax, input int ay, input int bx,
                           input int by, input int cx, input int cy,
                           input bit stall_en);
        int  stall_left = 0;
        bit  started = 1'b0;
        nacc     = 0;
        ndone    = 0;
        done_cyc = -1;
        first_v  = -1;
        start_tri(ax, ay, bx, by, cx, cy);
        for (int cyc = 1; cyc <= 2000 && ndone == 0; cyc++) begin
            @(negedge clk);
            if (stall_en && !started && nacc == 3) begin
                started    = 1'b1;
                stall_left = 5;
            end
            pix_ready = (stall_left == 0);
            if (stall_left > 0) begin
                chk("stall_valid", int'(pix_valid), 1);
                chk("stall_x", int'(pix_x), 3);
                chk("stall_y", int'(pix_y), 0);
                stall_left--;
            end
            if (pix_valid && first_v < 0) first_v = cyc;
            if (pix_valid && pix_ready) begin
                if (nacc < ex_q.size()) begin
                    chk("pix_x", int'(pix_x), ex_q[nacc]);
                    chk("pix_y", int'(pix_y), ey_q[nacc]);
                end else begin
                    chk("extra_pixel", nacc, ex_q.size());
                end
                nacc++;
            end
            if (tri_done) begin
                ndone++;
                done_cyc = cyc;
                chk("ready_at_done", int'(tri_ready), 1);
                chk("valid_at_done", int'(pix_valid), 0);
            end
        end
        if (ndone == 0) chk("done_timeout", 0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("quiet_valid", int'(pix_valid), 0);
            chk("quiet_done", int'(tri_done), 0);
        end
        pix_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        tri_valid = 1'b0;
        pix_ready = 1'b1;
        tri_ax = '0; tri_ay = '0; tri_bx = '0;
        tri_by = '0; tri_cx = '0; tri_cy = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(tri_ready), 1);
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_done", int'(tri_done), 0);
        chk("rst_x", int'(pix_x), 0);
        chk("rst_y", int'(pix_y), 0);

        // reset pulse while idle
        #2 rst_n = 1'b0;
        #1;
        chk("idle_rst_valid", int'(pix_valid), 0);
        chk("idle_rst_done", int'(tri_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rst_ready", int'(tri_ready), 1);

        // counter-clockwise small triangle
        fill_t2();
        run_tri(0, 0, 3, 0, 0, 3, 1'b0);
        chk("t2_count", nacc, 10);
        chk("t2_dones", ndone, 1);
        chk("t2_first_valid_cycle", first_v, 3);

        // clockwise winding
`ifdef TRI_RASTER_BACKFACE_EN
        fill_t2();
        run_tri(0, 0, 0, 3, 3, 0, 1'b0);
        chk("t3_count", nacc, 10);
`else
        ex_q.delete();
        ey_q.delete();
        run_tri(0, 0, 0, 3, 3, 0, 1'b0);
        chk("t3_count", nacc, 0);
`endif
        chk("t3_dones", ndone, 1);

        // covers whole screen
        fill_full();
        run_tri(-4, -4, 40, -4, -4, 40, 1'b0);
        chk("t4_count", nacc, 256);
        chk("t4_dones", ndone, 1);

        // entirely off screen
        ex_q.delete();
        ey_q.delete();
        run_tri(-9, -9, -2, -9, -9, -2, 1'b0);
        chk("t4b_count", nacc, 0);
        chk("t4b_dones", ndone, 1);
        chk("t4b_done_cycle", done_cyc, 2);

        // consumer back-pressure on the 4th pixel
        fill_t2();
        run_tri(0, 0, 3, 0, 0, 3, 1'b1);
        chk("t5_count", nacc, 10);
        chk("t5_dones", ndone, 1);

        // reset during scan
        pix_ready = 1'b1;
        start_tri(-4, -4, 40, -4, -4, 40);
        repeat (20) @(negedge clk);
        chk("t6_mid_valid", int'(pix_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(pix_valid), 0);
        chk("t6_rst_x", int'(pix_x), 0);
        chk("t6_rst_y", int'(pix_y), 0);
        chk("t6_rst_done", int'(tri_done), 0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_hold_done", int'(tri_done), 0);
            chk("t6_hold_valid", int'(pix_valid), 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_after_ready", int'(tri_ready), 1);
            chk("t6_after_valid", int'(pix_valid), 0);
            chk("t6_after_done", int'(tri_done), 0);
        end
        fill_t2();
        run_tri(0, 0, 3, 0, 0, 3, 1'b0);
        chk("t6_t2_count", nacc, 10);
        chk("t6_t2_dones", ndone, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
